col2img: RTL and testbench

Reassembles a serial stream of convolution results into a 2-D feature map: the inverse of the image-to-column unroller that feeds the MAC array. Elements arrive one per cycle in row-major order over a valid/ready handshake and are written into a 5x5 buffer. Output map size is derived from the kernel size and stride of the frame. The completed map is presented in parallel until the downstream pooling/writeback stage accepts it.

---
 rtl/col2img_if.sv | 24 ++
 rtl/col2img.sv | 112 +++++++++++
 tb/tb_col2img.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/col2img_if.sv
// Handshake bundle between the result stream, col2img and the downstream map consumer.
interface col2img_if #(parameter int data_width = 8);
  logic [2:0]                       k;
  logic                             stride;
  logic [data_width-1:0]            in_data;
  logic                             in_valid;
  logic                             in_last;
  logic                             in_ready;
  logic [4:0][4:0][data_width-1:0]  out_img;
  logic [2:0]                       out_dim;
  logic                             out_valid;
  logic                             out_ready;
  logic                             err;

  modport slave (
    input  k, stride, in_data, in_valid, in_last, out_ready,
    output in_ready, out_img, out_dim, out_valid, err
  );

  modport master (
    output k, stride, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_img, out_dim, out_valid, err
  );
endinterface

// File: rtl/col2img.sv
// Reassembles a row-major element stream into a 5x5 feature map sized by kernel/stride.
// Optional COL2IMG_RELU_EN: rectify negative elements to 0 as they are written.
module col2img #(
  parameter int data_width = 8
) (
  input  logic     clk,
  input  logic     nrst,
  col2img_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t                          r_state, w_next;
  logic [4:0][4:0][data_width-1:0] r_buf;
  logic [2:0]                      r_row, r_col, r_dim;
  logic                            r_err;
  logic                            r_live;

  logic                  w_accept, w_k_ok, w_final, w_write, w_clear, w_err;
  logic [2:0]            w_diff, w_dim_new, w_dim, w_row, w_col;
  logic [data_width-1:0] w_wdata;

  // r_live keeps in_ready low through reset and the release cycle, so in_ready stays a register decode
  assign bus.in_ready  = r_live && (r_state != DONE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_dim   = (r_state == DONE) ? r_dim : '0;
  assign bus.out_img   = r_buf;
  assign bus.err       = r_err;

  assign w_accept  = bus.in_valid && bus.in_ready;
  assign w_k_ok    = (bus.k >= 3'd1) && (bus.k <= 3'd5);
  assign w_diff    = 3'd5 - bus.k;
  assign w_dim_new = bus.stride ? (w_diff >> 1) + 3'd1 : w_diff + 3'd1;

  // The first element of a frame is handled in IDLE against the not-yet-latched geometry
  assign w_dim   = (r_state == IDLE) ? w_dim_new : r_dim;
  assign w_row   = (r_state == IDLE) ? '0 : r_row;
  assign w_col   = (r_state == IDLE) ? '0 : r_col;
  assign w_final = (w_row == w_dim - 3'd1) && (w_col == w_dim - 3'd1);

`ifdef COL2IMG_RELU_EN
  assign w_wdata = bus.in_data[data_width-1] ? '0 : bus.in_data;
`else
  assign w_wdata = bus.in_data;
`endif

  always_comb begin
    w_next  = r_state;
    w_write = 1'b0;
    w_clear = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      IDLE, FILL: begin
        if (w_accept) begin
          if ((r_state == IDLE) && !w_k_ok) begin
            w_err = 1'b1;
          end else if (w_final) begin
            w_write = 1'b1;
            w_next  = DONE;
            w_err   = !bus.in_last;
          end else if (bus.in_last) begin
            w_clear = 1'b1;
            w_err   = 1'b1;
            w_next  = IDLE;
          end else begin
            w_write = 1'b1;
            w_next  = FILL;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_clear = 1'b1;
          w_next  = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= IDLE;
      r_buf   <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_dim   <= '0;
      r_err   <= 1'b0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err;
      r_live  <= 1'b1;
      if (w_clear) begin
        r_buf <= '0;
        r_row <= '0;
        r_col <= '0;
      end else if (w_write) begin
        r_buf[w_row][w_col] <= w_wdata;
        if (w_col == w_dim - 3'd1) begin
          r_col <= '0;
          r_row <= w_row + 3'd1;
        end else begin
          r_col <= w_col + 3'd1;
          r_row <= w_row;
        end
        if (r_state == IDLE) r_dim <= w_dim_new;
      end
    end
  end

endmodule

// File: tb/tb_col2img.sv
// Directed plus randomized bench for col2img against an array-based reference of the map.
module tb_col2img;

  logic clk = 1'b0;
  logic nrst;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [7:0] din [25];

  always #5 clk = ~clk;

  col2img_if #(.data_width(8)) bus ();

  col2img #(.data_width(8)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int dim_of(input int k, input int s);
    return (5 - k) / (s + 1) + 1;
  endfunction

  function automatic logic [7:0] relu(input logic [7:0] d);
`ifdef COL2IMG_RELU_EN
    return d[7] ? 8'h00 : d;
`else
    return d;
`endif
  endfunction

  function automatic logic [199:0] model(input int dim);
    logic [4:0][4:0][7:0] m;
    m = '0;
    for (int r = 0; r < dim; r++)
      for (int c = 0; c < dim; c++)
        m[r][c] = relu(din[r * dim + c]);
    return m;
  endfunction

  task automatic push(input logic [7:0] d, input logic last, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("push_ready_timeout", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic frame(input int k, input int s, input int gmin, input int gmax, input int hold);
    int dim, n;
    logic [199:0] e;
    dim = dim_of(k, s);
    n   = dim * dim;
    e   = model(dim);
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        bus.k      = k[2:0];
        bus.stride = s[0];
      end else begin
        bus.k      = 3'($urandom);
        bus.stride = 1'($urandom);
      end
      push(din[i], (i == n - 1), $urandom_range(gmax, gmin));
      if (i < n - 1) chk("fill_out_valid", bus.out_valid, 0);
    end
    chk("done_out_valid", bus.out_valid, 1);
    chk("done_out_dim", bus.out_dim, dim);
    chk("done_err", bus.err, 0);
    chk("done_img", bus.out_img, e);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    for (int h = 0; h < hold; h++) begin
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_img", bus.out_img, e);
      @(negedge clk);
    end
    chk("pre_hs_img", bus.out_img, e);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("post_hs_out_valid", bus.out_valid, 0);
    chk("post_hs_in_ready", bus.in_ready, 1);
    chk("post_hs_img", bus.out_img, 0);
    chk("post_hs_dim", bus.out_dim, 0);
  endtask

  initial begin
    nrst          = 1'b0;
    bus.k         = '0;
    bus.stride    = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_dim", bus.out_dim, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_img", bus.out_img, 0);
    nrst = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", bus.in_ready, 1);

    // k=3 stride 1: 1..9, immediate handshake
    for (int i = 0; i < 9; i++) din[i] = 8'(i + 1);
    frame(3, 0, 0, 0, 0);

    // k=1 stride 2: in_valid every other cycle, downstream stalls 5 cycles
    for (int i = 0; i < 9; i++) din[i] = 8'($urandom);
    frame(1, 1, 1, 1, 5);

    // k=5: single-element frame
    din[0] = 8'h7F;
    frame(5, 0, 0, 0, 0);

    // illegal kernel size drops the element
    bus.k = 3'd6;
    push(8'h55, 1'b0, 0);
    chk("k6_err", bus.err, 1);
    chk("k6_in_ready", bus.in_ready, 1);
    chk("k6_img", bus.out_img, 0);

    // early last on the 3rd of 16 elements
    bus.k = 3'd2;
    bus.stride = 1'b0;
    push(8'h01, 1'b0, 0);
    chk("k2_first_err", bus.err, 0);
    push(8'h02, 1'b0, 0);
    push(8'h03, 1'b1, 0);
    chk("early_err", bus.err, 1);
    chk("early_out_valid", bus.out_valid, 0);
    chk("early_img", bus.out_img, 0);
    chk("early_in_ready", bus.in_ready, 1);
    @(negedge clk);
    chk("early_err_pulse", bus.err, 0);

    // final element without in_last still completes, flags err
    bus.k = 3'd5;
    bus.stride = 1'b1;
    push(8'h3C, 1'b0, 0);
    chk("nolast_out_valid", bus.out_valid, 1);
    chk("nolast_err", bus.err, 1);
    chk("nolast_dim", bus.out_dim, 1);
    chk("nolast_img00", bus.out_img[0][0], relu(8'h3C));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("nolast_err_pulse", bus.err, 0);
    chk("nolast_idle", bus.out_valid, 0);

    // reset mid-frame after 10 of 25 elements
    bus.k = 3'd1;
    bus.stride = 1'b0;
    for (int i = 0; i < 10; i++) push(8'($urandom), 1'b0, 0);
    chk("mid_out_valid", bus.out_valid, 0);
    nrst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_dim", bus.out_dim, 0);
    chk("mid_rst_err", bus.err, 0);
    chk("mid_rst_img", bus.out_img, 0);
    nrst = 1'b1;
    @(negedge clk);
    chk("mid_rel_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 25; i++) din[i] = 8'($urandom);
    frame(1, 0, 0, 0, 1);

    // signed extremes, rectified only when the option is built in
    din[0] = 8'h80;
    din[1] = 8'h05;
    din[2] = 8'hFF;
    din[3] = 8'h7F;
    frame(4, 0, 0, 0, 0);

    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 25; i++) din[i] = 8'($urandom);
      frame($urandom_range(5, 1), $urandom_range(1, 0), 0, 2, $urandom_range(3, 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
